wrp_shff_uram_fifo_axis: RTL

WRP_SHFF_URAM_FIFO_AXIS -- requirements
Module: wrp_shff_uram_fifo_axis

---
 rtl/wrp_shff_uram_fifo_axis.sv | 122 ++++++++++++
 1 files changed

// File: rtl/wrp_shff_uram_fifo_axis.sv
// AXI-Stream FIFO built on a single-clock UltraRAM with a multi-cycle read pipeline.
// A credit-limited output buffer absorbs read latency so both sides sustain one word per cycle.
module wrp_shff_uram_fifo_axis #(
  parameter int ADDR_WIDTH       = 12,
  parameter int DATA_WIDTH       = 128,
  parameter int READ_LATENCY     = 5,
  parameter int PROG_FULL_THRESH = 2**ADDR_WIDTH - 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [ADDR_WIDTH+1:0] occupancy,
  output logic                  prog_full
);

  localparam int DEPTH      = 2**ADDR_WIDTH;
  localparam int OBUF_DEPTH = READ_LATENCY + 4;
  localparam int OB_AW      = $clog2(OBUF_DEPTH);
  localparam int CR_W       = $clog2(OBUF_DEPTH + 1);
  localparam int OCC_W      = ADDR_WIDTH + 2;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] pipe_data [READ_LATENCY];
  logic [DATA_WIDTH-1:0] obuf [OBUF_DEPTH];
  logic [READ_LATENCY-1:0] pipe_vld;
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   mem_count;
  logic [CR_W-1:0]       credits, ob_count;
  logic [OB_AW-1:0]      ob_head, ob_tail;
  logic [OCC_W-1:0]      occ_next;
  logic                  s_fire, m_fire, rd_issue, ob_push;

  function automatic logic [OB_AW-1:0] ob_inc(input logic [OB_AW-1:0] p);
    return (p == OB_AW'(OBUF_DEPTH - 1)) ? '0 : p + OB_AW'(1);
  endfunction

  // Memory is full exactly when the count's top bit is set.
  assign s_tready = !rst && !mem_count[ADDR_WIDTH];
  assign m_tvalid = !rst && (ob_count != '0);
  assign m_tdata  = rst ? '0 : obuf[ob_head];
  assign s_fire   = s_tvalid && s_tready;
  assign m_fire   = m_tvalid && m_tready;
  assign rd_issue = (mem_count != '0) && (credits < CR_W'(OBUF_DEPTH));
  assign ob_push  = pipe_vld[READ_LATENCY-1];

  // NOTE: storage and read-pipeline data carry no reset; pipe_vld alone qualifies the data.
  always_ff @(posedge clk) begin
    if (s_fire) mem[wr_ptr] <= s_tdata;
    pipe_data[0] <= mem[rd_ptr];
    for (int i = 1; i < READ_LATENCY; i++) pipe_data[i] <= pipe_data[i-1];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_count <= '0;
      credits   <= '0;
      pipe_vld  <= '0;
    end else begin
      if (s_fire)   wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (rd_issue) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      case ({s_fire, rd_issue})
        2'b10:   mem_count <= mem_count + (ADDR_WIDTH+1)'(1);
        2'b01:   mem_count <= mem_count - (ADDR_WIDTH+1)'(1);
        default: mem_count <= mem_count;
      endcase
      case ({rd_issue, m_fire})
        2'b10:   credits <= credits + CR_W'(1);
        2'b01:   credits <= credits - CR_W'(1);
        default: credits <= credits;
      endcase
      pipe_vld[0] <= rd_issue;
      for (int i = 1; i < READ_LATENCY; i++) pipe_vld[i] <= pipe_vld[i-1];
    end
  end

  // Output buffer: credits guarantee a free slot for every word leaving the read pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      ob_head  <= '0;
      ob_tail  <= '0;
      ob_count <= '0;
      for (int i = 0; i < OBUF_DEPTH; i++) obuf[i] <= '0;
    end else begin
      if (ob_push) begin
        obuf[ob_tail] <= pipe_data[READ_LATENCY-1];
        ob_tail       <= ob_inc(ob_tail);
      end
      if (m_fire) ob_head <= ob_inc(ob_head);
      case ({ob_push, m_fire})
        2'b10:   ob_count <= ob_count + CR_W'(1);
        2'b01:   ob_count <= ob_count - CR_W'(1);
        default: ob_count <= ob_count;
      endcase
    end
  end

  // NOTE: combinational outputs get a default first so no path can infer a latch.
  always_comb begin
    occ_next = occupancy;
    if (s_fire && !m_fire)      occ_next = occupancy + OCC_W'(1);
    else if (m_fire && !s_fire) occ_next = occupancy - OCC_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occupancy <= '0;
      prog_full <= 1'b0;
    end else begin
      occupancy <= occ_next;
      prog_full <= (occ_next >= OCC_W'(PROG_FULL_THRESH));
    end
  end

endmodule
